pipeline_stall_ctrl: RTL

//  Central stall controller; drives the stall[5:0] vector consumed by the PC, IF_ID, ID_EX, EX_MEM, MEM_WB registers.

---
 rtl/pipeline_stall_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/pipeline_stall_ctrl.sv
// Central pipeline stall controller.
// Arbitrates stall requests from IF, ID, EX and MEM into the stall vector
// consumed by the PC and the inter-stage pipeline registers, sequences
// multi-cycle EX operations and guards MEM waits with a sticky watchdog.
// Stall bit map: [0]=PC [1]=IF [2]=ID [3]=EX [4]=MEM [5]=WB.
//
// Ports
//   clk                clock, all state on posedge
//   rst_n              asynchronous active-low reset
//   stallreq_if_i      IF fetch not ready
//   stallreq_id_i      ID load-use hazard
//   ex_multi_start_i   EX begins a multi-cycle op (held high while held off)
//   stallreq_mem_i     MEM access not complete
//   timeout_clr_i      clears sticky watchdog flag
//   stall_o            stall vector (combinational)
//   ex_multi_done_o    multi-cycle result valid this cycle (combinational)
//   mem_timeout_o      sticky watchdog error flag (registered)
//   stall_cycles_o     saturating count of cycles with stall[0]=1 (registered)
module pipeline_stall_ctrl #(
    parameter int unsigned MULTI_CYCLES = 4,
    parameter int unsigned MEM_TIMEOUT  = 64,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stallreq_if_i,
    input  logic             stallreq_id_i,
    input  logic             ex_multi_start_i,
    input  logic             stallreq_mem_i,
    input  logic             timeout_clr_i,
    output logic [5:0]       stall_o,
    output logic             ex_multi_done_o,
    output logic             mem_timeout_o,
    output logic [CNT_W-1:0] stall_cycles_o
);

    localparam int unsigned EX_CNT_W  = 8;
    localparam int unsigned MEM_CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    localparam logic [EX_CNT_W-1:0]  EX_LOAD  = EX_CNT_W'(MULTI_CYCLES - 2);
    localparam logic [MEM_CNT_W-1:0] MEM_LAST = MEM_CNT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]     CNT_MAX  = '1;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_EX_BUSY = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [EX_CNT_W-1:0]  ex_cnt_q, ex_cnt_d;
    logic [MEM_CNT_W-1:0] mem_cnt_q, mem_cnt_d;
    logic                 mem_timeout_q, mem_timeout_d;
    logic [CNT_W-1:0]     stall_cycles_q, stall_cycles_d;

    logic                 mem_req;
    logic                 ex_busy;
    logic                 ex_cnt_zero;

    // Request qualification; a tripped watchdog masks further MEM stalls
    always_comb begin
        mem_req     = stallreq_mem_i && !mem_timeout_q;
        ex_cnt_zero = (ex_cnt_q == '0);
        ex_busy     = ((state_q == ST_RUN) && ex_multi_start_i) ||
                      ((state_q == ST_EX_BUSY) && !ex_cnt_zero);
    end

    // Priority stall encoding; forced idle while reset is asserted
    always_comb begin
        stall_o         = 6'b000000;
        ex_multi_done_o = 1'b0;
        if (rst_n) begin
            if (mem_req)            stall_o = 6'b011111;
            else if (ex_busy)       stall_o = 6'b001111;
            else if (stallreq_id_i) stall_o = 6'b000111;
            else if (stallreq_if_i) stall_o = 6'b000011;
            ex_multi_done_o = (state_q == ST_EX_BUSY) && ex_cnt_zero && !mem_req;
        end
    end

    // EX sequencer; a MEM wait freezes both state and countdown
    always_comb begin
        state_d  = state_q;
        ex_cnt_d = ex_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (ex_multi_start_i && !mem_req) begin
                    state_d  = ST_EX_BUSY;
                    ex_cnt_d = EX_LOAD;
                end
            end
            ST_EX_BUSY: begin
                if (!mem_req) begin
                    if (ex_cnt_zero) state_d  = ST_RUN;
                    else             ex_cnt_d = ex_cnt_q - EX_CNT_W'(1);
                end
            end
            default: begin
                state_d  = ST_RUN;
                ex_cnt_d = '0;
            end
        endcase
    end

    // MEM watchdog; clear takes precedence over a simultaneous trip
    always_comb begin
        mem_timeout_d = mem_timeout_q;
        mem_cnt_d     = mem_cnt_q;
        if (timeout_clr_i) begin
            mem_timeout_d = 1'b0;
            mem_cnt_d     = '0;
        end else if (!stallreq_mem_i) begin
            mem_cnt_d = '0;
        end else if (!mem_timeout_q) begin
            if (mem_cnt_q == MEM_LAST) begin
                mem_timeout_d = 1'b1;
                mem_cnt_d     = '0;
            end else begin
                mem_cnt_d = mem_cnt_q + MEM_CNT_W'(1);
            end
        end
    end

    // Saturating PC-stall performance counter
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall_o[0] && (stall_cycles_q != CNT_MAX)) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_RUN;
            ex_cnt_q       <= '0;
            mem_cnt_q      <= '0;
            mem_timeout_q  <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            ex_cnt_q       <= ex_cnt_d;
            mem_cnt_q      <= mem_cnt_d;
            mem_timeout_q  <= mem_timeout_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign mem_timeout_o  = mem_timeout_q;
    assign stall_cycles_o = stall_cycles_q;

endmodule
